// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit with valid/ready on both sides and flush.
// Optional macro MDU_DIV_FAST_EN: short-circuits divisions by zero or with |dividend| < |divisor|.
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_div_zero,
    output logic             busy
);

    localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MOD   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MODU  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r, state_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [2:0]         op_r, op_n;
    logic [WIDTH-1:0]   a_r, a_n, b_r, b_n;
    logic [WIDTH-1:0]   quo_r, quo_n, rem_r, rem_n, dvs_r, dvs_n;
    logic               skip_r, skip_n;
    logic [WIDTH-1:0]   res_r, res_n;
    logic               dz_r, dz_n;
    logic               out_valid_r, busy_r;

    logic               accept_s, in_is_mul_s, in_signed_s;
    logic [WIDTH-1:0]   in_mag_a_s, in_mag_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mulh_s, mul_res_s, div_res_s, q_fix_s, r_fix_s;
    logic [WIDTH:0]     trial_s;
    logic               div_signed_s, sign_a_s, sign_b_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    // Issue-side decode of the incoming op
    always_comb begin
        in_is_mul_s = 1'b1;
        in_signed_s = 1'b0;
        case (in_op)
            OP_DIV, OP_MOD: begin
                in_is_mul_s = 1'b0;
                in_signed_s = 1'b1;
            end
            OP_DIVU, OP_MODU: in_is_mul_s = 1'b0;
            default:          in_is_mul_s = 1'b1;
        endcase
    end

    assign in_mag_a_s = magnitude(in_src1, in_signed_s);
    assign in_mag_b_s = magnitude(in_src2, in_signed_s);
    assign in_ready   = ~flush & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready));
    assign accept_s   = in_valid & in_ready;

    // Signed high half is derived from the unsigned product by subtracting the sign corrections
    assign prod_s = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
    assign mulh_s = prod_s[2*WIDTH-1:WIDTH] - (a_r[WIDTH-1] ? b_r : '0) - (b_r[WIDTH-1] ? a_r : '0);

    // Multiply result select
    always_comb begin
        mul_res_s = prod_s[WIDTH-1:0];
        case (op_r)
            OP_MULH:  mul_res_s = mulh_s;
            OP_MULHU: mul_res_s = prod_s[2*WIDTH-1:WIDTH];
            default:  mul_res_s = prod_s[WIDTH-1:0];
        endcase
    end

    assign div_signed_s = (op_r == OP_DIV) | (op_r == OP_MOD);
    assign sign_a_s     = div_signed_s & a_r[WIDTH-1];
    assign sign_b_s     = div_signed_s & b_r[WIDTH-1];
    assign trial_s      = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};

    // Sign fixup and zero-divisor override of the magnitude quotient/remainder
    always_comb begin
        q_fix_s = quo_r;
        r_fix_s = rem_r;
        if (b_r == '0) begin
            q_fix_s = '1;
            r_fix_s = a_r;
        end else begin
            q_fix_s = (sign_a_s ^ sign_b_s) ? -quo_r : quo_r;
            r_fix_s = sign_a_s ? -rem_r : rem_r;
        end
        if ((op_r == OP_MOD) || (op_r == OP_MODU)) begin
            div_res_s = r_fix_s;
        end else begin
            div_res_s = q_fix_s;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        op_n    = op_r;
        a_n     = a_r;
        b_n     = b_r;
        quo_n   = quo_r;
        rem_n   = rem_r;
        dvs_n   = dvs_r;
        skip_n  = skip_r;
        res_n   = res_r;
        dz_n    = dz_r;
        case (state_r)
            ST_IDLE: state_n = ST_IDLE;
            ST_MUL: begin
                if (cnt_r == CNT_W'(MUL_STAGES - 1)) begin
                    state_n = ST_DONE;
                    res_n   = mul_res_s;
                    dz_n    = 1'b0;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            ST_DIV: begin
                if (cnt_r < CNT_W'(WIDTH)) begin
                    cnt_n = cnt_r + 1'b1;
                    if (skip_r) begin
                        quo_n = quo_r;
                    end else if (!trial_s[WIDTH]) begin
                        rem_n = trial_s[WIDTH-1:0];
                        quo_n = {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_n = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
                        quo_n = {quo_r[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    state_n = ST_DONE;
                    res_n   = div_res_s;
                    dz_n    = (b_r == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (accept_s) begin
            state_n = in_is_mul_s ? ST_MUL : ST_DIV;
            cnt_n   = '0;
            op_n    = in_op;
            a_n     = in_src1;
            b_n     = in_src2;
            quo_n   = in_mag_a_s;
            rem_n   = '0;
            dvs_n   = in_mag_b_s;
            skip_n  = 1'b0;
`ifdef MDU_DIV_FAST_EN
            // Trivial divisions finish after one idle iteration slot plus the fixup cycle
            if (!in_is_mul_s && ((in_src2 == '0) || (in_mag_a_s < in_mag_b_s))) begin
                skip_n = 1'b1;
                cnt_n  = CNT_W'(WIDTH - 1);
                quo_n  = '0;
                rem_n  = in_mag_a_s;
            end else begin
                skip_n = 1'b0;
            end
`endif
        end else begin
            skip_n = skip_n;
        end

        if (flush) begin
            state_n = ST_IDLE;
        end else begin
            state_n = state_n;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_r        <= 3'd0;
            a_r         <= '0;
            b_r         <= '0;
            quo_r       <= '0;
            rem_r       <= '0;
            dvs_r       <= '0;
            skip_r      <= 1'b0;
            res_r       <= '0;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            op_r        <= op_n;
            a_r         <= a_n;
            b_r         <= b_n;
            quo_r       <= quo_n;
            rem_r       <= rem_n;
            dvs_r       <= dvs_n;
            skip_r      <= skip_n;
            res_r       <= res_n;
            dz_r        <= dz_n;
            out_valid_r <= (state_n == ST_DONE);
            busy_r      <= (state_n != ST_IDLE);
        end
    end

    assign out_valid    = out_valid_r;
    assign out_result   = res_r;
    assign out_div_zero = dz_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors push expectations, a monitor pops on handshake.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready, out_div_zero, busy;
    logic [2:0]  in_op;
    logic [31:0] in_src1, in_src2, out_result;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          lat;
        int          t;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          seen   = 1'b0;
    logic [31:0] held;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;
`ifdef MDU_DIV_FAST_EN
    localparam int FAST_LAT = 2;
`else
    localparam int FAST_LAT = 33;
`endif

    mul_div_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_div_zero(out_div_zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: sample on the falling edge, compare on every output handshake
    always @(negedge clk) begin
        if (resetn && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    held = out_result;
                    chk("latency", 32'(cyc - sb_q[0].t), 32'(sb_q[0].lat));
                end else begin
                    chk("held_stable", out_result, held);
                end
                if (out_ready) begin
                    chk("result", out_result, sb_q[0].res);
                    chk("div_zero", {31'd0, out_div_zero}, {31'd0, sb_q[0].dz});
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic dz, input int lat, input bit expect_out);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", {31'd0, in_ready}, 32'd1);
            #1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.res = res;
            e.dz  = dz;
            e.lat = lat;
            e.t   = cyc;
            if (expect_out) sb_q.push_back(e);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_src1 = 32'd0; in_src2 = 32'd0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_div_zero", {31'd0, out_div_zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Multiplies
        issue(3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0, MUL_LAT, 1'b1);
        issue(3'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1'b0, MUL_LAT, 1'b1);
        issue(3'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 1'b0, MUL_LAT, 1'b1);
        issue(3'd7, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0, MUL_LAT, 1'b1);
        issue(3'd1, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 1'b0, MUL_LAT, 1'b1);
        issue(3'd2, 32'hFFFFFFFE, 32'h3, 32'h00000002, 1'b0, MUL_LAT, 1'b1);
        issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, MUL_LAT, 1'b1);
        drain();

        // Divides: signs, overflow, small dividend, zero divisor
        issue(3'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b1);
        issue(3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, DIV_LAT, 1'b1);
        issue(3'd5, 32'h7, 32'h2, 32'h3, 1'b0, DIV_LAT, 1'b1);
        issue(3'd6, 32'h7, 32'h2, 32'h1, 1'b0, DIV_LAT, 1'b1);
        issue(3'd3, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b1);
        issue(3'd4, 32'h7, 32'hFFFFFFFE, 32'h1, 1'b0, DIV_LAT, 1'b1);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, DIV_LAT, 1'b1);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, DIV_LAT, 1'b1);
        issue(3'd5, 32'h3, 32'hA, 32'h0, 1'b0, FAST_LAT, 1'b1);
        issue(3'd4, 32'hFFFFFFFD, 32'hA, 32'hFFFFFFFD, 1'b0, FAST_LAT, 1'b1);
        issue(3'd5, 32'h5, 32'h0, 32'hFFFFFFFF, 1'b1, FAST_LAT, 1'b1);
        issue(3'd6, 32'h5, 32'h0, 32'h5, 1'b1, FAST_LAT, 1'b1);
        issue(3'd3, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 1'b1, FAST_LAT, 1'b1);
        issue(3'd4, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 1'b1, FAST_LAT, 1'b1);
        drain();

        // Flush mid-divide: sampled at edge T+10, MUL accepted at T+11
        issue(3'd5, 32'h64, 32'h7, 32'h0, 1'b0, DIV_LAT, 1'b0);
        repeat (9) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        issue(3'd0, 32'h6, 32'h7, 32'h2A, 1'b0, MUL_LAT, 1'b1);
        drain();

        // Asynchronous reset mid-divide
        issue(3'd5, 32'h64, 32'h7, 32'h0, 1'b0, DIV_LAT, 1'b0);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", out_result, 32'd0);
        chk("arst_div_zero", {31'd0, out_div_zero}, 32'd0);
        @(posedge clk);
        #2 resetn = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        chk("arst_no_result", 32'(sb_q.size()), 32'd0);
        issue(3'd0, 32'h3, 32'h5, 32'hF, 1'b0, MUL_LAT, 1'b1);
        drain();

        // Backpressure: hold 5 cycles, then consume and accept in the same cycle
        out_ready = 1'b0;
        issue(3'd0, 32'h1234, 32'h10, 32'h12340, 1'b0, MUL_LAT, 1'b1);
        fork
            issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, MUL_LAT, 1'b1);
            begin
                repeat (7) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
